ustc_crossbar: RTL and testbench
================================

Name: ustc_crossbar

Overview:
- Parameterised N-input, N-output data crossbar with a registered output stage.
- Each output lane selects one input lane using an N-bit one-hot control row.
- Routes operand lanes between buffers and the sparse tensor-core compute array (e.g. operand gather/permutation).

Parameters:
- N, 8, number of input lanes and output lanes (>=2).
- DW_DATA, 8, bit width of each data lane.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl  input  N*N  routing matrix; row i = ctrl[i*N +: N] controls output lane i; bit j of row i set means output i takes input j.
- in  input  N*DW_DATA  input lanes; lane j = in[j*DW_DATA +: DW_DATA].
- out  output  N*DW_DATA  output lanes; lane i = out[i*DW_DATA +: DW_DATA].

Behaviour:
- Reset is synchronous and active-high: on a rising clk edge with reset=1, all out lanes become 0.
  - reset dominates any ctrl/in activity in the same cycle.
  - Asserting reset mid-stream clears out on that edge.
  - No state survives reset.
- Routing, combinational part: sel_i = OR over j of (ctrl[i*N+j] ? in lane j : 0).
  - Implemented as an AND-OR mux per output lane; no priority logic.
- Output register: on each rising edge with reset=0, out lane i <= sel_i.
  - Latency is 1 cycle from ctrl/in to out.
  - ctrl and in are sampled together on the same edge.
- One-hot row: output i equals exactly input j.
- All-zero row: output i = 0.
- Multi-hot row: output i = bitwise OR of all selected input lanes. This is defined behaviour, not an error.
- Broadcast: one input may feed any number of outputs (multiple rows selecting the same column is legal).
- Any permutation, broadcast or partial mapping is allowed. No handshake; the block accepts new ctrl/in every cycle (throughput 1 per cycle).
- Unused or unselected inputs have no effect.
- All lanes are treated as unsigned bit vectors; no arithmetic.
- No X propagation from ctrl rows that are all-zero.

Optional Feature:
- Macro: USTC_CROSSBAR_IN_REG_EN.
- When defined:
  - An input register stage captures ctrl and in on each rising edge; it is cleared to 0 by synchronous reset.
  - The output register is fed from these registered values.
  - Total latency is 2 cycles.
  - After reset deasserts, out stays 0 for the first post-reset edge.
- When undefined: single output register only, latency 1 cycle (default).

Test Plan:
- Identity:
  - Stimulus: in = {7,6,5,4,3,2,1,0} (lane j = j); row i = 1<<i; hold reset=1 for one edge, then deassert.
  - Required: out = 0 while in reset; from the first edge after deassert, out lane i = i, i.e. out = {7,6,5,4,3,2,1,0}.
- Reversal:
  - Stimulus: same in; row i = 1<<(7-i).
  - Required: out lane i = 7-i one cycle later, i.e. out = {0,1,2,3,4,5,6,7}.
- Broadcast plus zero row:
  - Stimulus: rows 0..6 = 8'b00001000, row 7 = 0.
  - Required: out lanes 0..6 = 3; lane 7 = 0.
- Multi-hot OR:
  - Stimulus: in lane 1 = 8'h0F, lane 2 = 8'hF0; row 0 = 8'b00000110.
  - Required: out lane 0 = 8'hFF.
- Back-to-back update:
  - Stimulus: change ctrl from identity to reversal on consecutive cycles.
  - Required: out changes on the very next edge each cycle (1-cycle latency, no bubbles).
  - With USTC_CROSSBAR_IN_REG_EN defined: same sequence delayed by one extra cycle.
- Mid-operation reset:
  - Stimulus: assert reset for one cycle while identity traffic is flowing.
  - Required: out = 0 on that edge; out resumes correct routing one cycle after deassert (two cycles with USTC_CROSSBAR_IN_REG_EN defined).

Source files
------------

// File: rtl/ustc_crossbar.sv
// N x N one-hot-row data crossbar with a registered output stage (AND-OR mux per output lane).
// Optional macro USTC_CROSSBAR_IN_REG_EN adds an input register stage (total latency 2).
module ustc_crossbar #(
    parameter int N       = 8,
    parameter int DW_DATA = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*N-1:0]       ctrl,
    input  logic [N*DW_DATA-1:0] in,
    output logic [N*DW_DATA-1:0] out
);

    logic [N*N-1:0]       w_ctrl;
    logic [N*DW_DATA-1:0] w_in;
    logic [N*DW_DATA-1:0] w_sel;
    logic [N*DW_DATA-1:0] r_out_p1;

    // Every selected lane is ORed in, so multi-hot rows merge and all-zero rows give 0.
    function automatic logic [DW_DATA-1:0] lane_mux(
        input logic [N-1:0]         row,
        input logic [N*DW_DATA-1:0] lanes
    );
        logic [DW_DATA-1:0] acc;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = acc | (lanes[j*DW_DATA +: DW_DATA] & {DW_DATA{row[j]}});
        end
        return acc;
    endfunction

`ifdef USTC_CROSSBAR_IN_REG_EN
    logic [N*N-1:0]       r_ctrl_p0;
    logic [N*DW_DATA-1:0] r_in_p0;

    // Stage p0: capture ctrl and data together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_p0 <= '0;
            r_in_p0   <= '0;
        end else begin
            r_ctrl_p0 <= ctrl;
            r_in_p0   <= in;
        end
    end

    assign w_ctrl = r_ctrl_p0;
    assign w_in   = r_in_p0;
`else
    assign w_ctrl = ctrl;
    assign w_in   = in;
`endif

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            w_sel[i*DW_DATA +: DW_DATA] = lane_mux(w_ctrl[i*N +: N], w_in);
        end
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_p1 <= '0;
        end else begin
            r_out_p1 <= w_sel;
        end
    end

    assign out = r_out_p1;

endmodule

// File: tb/tb_ustc_crossbar.sv
// Self-checking bench for ustc_crossbar: directed table, hand sequences and a randomized reference-model phase.
module tb_ustc_crossbar;

    localparam int N  = 8;
    localparam int DW = 8;
`ifdef USTC_CROSSBAR_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [63:0] ID_CTRL  = 64'h80_40_20_10_08_04_02_01;
    localparam logic [63:0] REV_CTRL = 64'h01_02_04_08_10_20_40_80;
    localparam logic [63:0] ID_IN    = 64'h07_06_05_04_03_02_01_00;
    localparam logic [63:0] REV_OUT  = 64'h00_01_02_03_04_05_06_07;

    logic          clk;
    logic          reset;
    logic [N*N-1:0]  ctrl;
    logic [N*DW-1:0] din;
    logic [N*DW-1:0] out;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected output plus a delay line when the input stage is present
    logic [N*DW-1:0] m_out;
    logic [N*N-1:0]  m_ctrl_d;
    logic [N*DW-1:0] m_in_d;

    ustc_crossbar #(.N(N), .DW_DATA(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .in    (din),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // For every input lane, scatter it into each output whose row selects it.
    function automatic logic [N*DW-1:0] route(input logic [N*N-1:0] c, input logic [N*DW-1:0] d);
        logic [DW-1:0] res [N];
        logic [N*DW-1:0] packed_res;
        for (int i = 0; i < N; i++) res[i] = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (c[i*N + j]) res[i] = res[i] | d[j*DW +: DW];
            end
        end
        packed_res = '0;
        for (int i = 0; i < N; i++) packed_res[i*DW +: DW] = res[i];
        return packed_res;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: update the model from the inputs sampled at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (LAT == 1) begin
            m_out = reset ? '0 : route(ctrl, din);
        end else begin
            m_out    = reset ? '0 : route(m_ctrl_d, m_in_d);
            m_ctrl_d = reset ? '0 : ctrl;
            m_in_d   = reset ? '0 : din;
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic [63:0] c, input logic [63:0] d);
        reset = r;
        ctrl  = c;
        din   = d;
    endtask

    typedef struct {
        string       name;
        logic [63:0] c;
        logic [63:0] d;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [63:0] rand_ctrl();
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: c[i*N +: N] = 8'h00;
                1, 2: c[i*N +: N] = 8'(1 << $urandom_range(0, N-1));
                default: c[i*N +: N] = 8'($urandom);
            endcase
        end
        return c;
    endfunction

    initial begin
        logic [63:0] seq_c [6];
        logic [63:0] seq_e [6];
        logic [63:0] rd;

        m_out    = '0;
        m_ctrl_d = '0;
        m_in_d   = '0;

        vecs[0] = '{"identity",  ID_CTRL,  ID_IN, ID_IN};
        vecs[1] = '{"reversal",  REV_CTRL, ID_IN, REV_OUT};
        vecs[2] = '{"broadcast", 64'h00_08_08_08_08_08_08_08, ID_IN, 64'h00_03_03_03_03_03_03_03};
        vecs[3] = '{"multihot",  64'h00_00_00_00_00_00_00_06, 64'h07_06_05_04_03_F0_0F_00, 64'h00_00_00_00_00_00_00_FF};
        vecs[4] = '{"allzero",   64'h0, 64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[5] = '{"fullrow",   64'h00_00_00_00_00_00_00_FF, ID_IN, 64'h00_00_00_00_00_00_00_07};

        // Identity out of reset
        drive(1'b1, ID_CTRL, ID_IN);
        tick();
        check("reset_out", out, 64'h0);
        tick();
        check("reset_hold", out, 64'h0);
        drive(1'b0, ID_CTRL, ID_IN);
        tick();
        if (LAT == 2) begin
            check("post_reset_first_edge", out, 64'h0);
            tick();
        end
        check("identity_after_reset", out, ID_IN);

        // Directed table: hold each vector LAT edges, then compare
        foreach (vecs[k]) begin
            drive(1'b0, vecs[k].c, vecs[k].d);
            for (int t = 0; t < LAT; t++) tick();
            check(vecs[k].name, out, vecs[k].exp);
        end

        // Back-to-back ctrl changes after a quiet all-zero period
        drive(1'b0, 64'h0, ID_IN);
        for (int t = 0; t < LAT + 1; t++) tick();
        check("b2b_quiet", out, 64'h0);
        for (int t = 0; t < 6; t++) begin
            seq_c[t] = (t % 2 == 0) ? ID_CTRL : REV_CTRL;
            seq_e[t] = (t % 2 == 0) ? ID_IN   : REV_OUT;
        end
        for (int t = 0; t < 6; t++) begin
            drive(1'b0, seq_c[t], ID_IN);
            tick();
            check($sformatf("b2b_%0d", t), out, (t - LAT + 1 < 0) ? 64'h0 : seq_e[t - LAT + 1]);
        end

        // Mid-stream reset with identity traffic
        drive(1'b0, ID_CTRL, ID_IN);
        for (int t = 0; t < LAT + 1; t++) tick();
        check("mid_pre", out, ID_IN);
        drive(1'b1, ID_CTRL, ID_IN);
        tick();
        check("mid_reset", out, 64'h0);
        drive(1'b0, ID_CTRL, ID_IN);
        tick();
        if (LAT == 2) begin
            check("mid_resume_gap", out, 64'h0);
            tick();
        end
        check("mid_resume", out, ID_IN);

        // Randomized traffic against the reference model
        for (int t = 0; t < 400; t++) begin
            rd = {$urandom, $urandom};
            drive(($urandom_range(0, 19) == 0), rand_ctrl(), rd);
            tick();
            check("random", out, m_out);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
